// File: rtl/ad76xx_par_rd_ctrl.sv
// Parallel-read controller for AD7656-class ADCs: CONVST, BUSY wait with timeout, CS_N/RD_N burst.
// Define AD76XX_ERR_CNT_EN to add the saturating err_cnt_o error counter.
module ad76xx_par_rd_ctrl #(
  parameter int CH_NUM       = 6,
  parameter int DW           = 16,
  parameter int CONVST_W     = 3,
  parameter int BUSY_TIMEOUT = 400,
  parameter int CS_SETUP     = 6,
  parameter int RD_LOW       = 9,
  parameter int RD_HIGH      = 3,
  parameter int QUIET        = 8,
  parameter int RST_HOLD     = 16,
  parameter int AUTO_PERIOD  = 0
) (
  input  logic                   sys_clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   busy_i,
  input  logic [DW-1:0]          db_i,
  output logic [CONVST_W-1:0]    convst_o,
  output logic                   cs_n_o,
  output logic                   rd_n_o,
  output logic                   adc_reset_o,
  output logic                   ready_o,
  output logic [CH_NUM*DW-1:0]   ch_data_o,
  output logic                   data_valid_o,
  output logic                   timeout_o,
  output logic                   overrun_o
`ifdef AD76XX_ERR_CNT_EN
  ,
  output logic [15:0]            err_cnt_o
`endif
);

  localparam int IW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [2:0] {
    S_RST, S_IDLE, S_CONV, S_CS, S_RD_LO, S_RD_HI, S_DONE, S_QUIET
  } state_t;

  state_t                        r_state;
  logic [15:0]                   r_cnt;
  logic [IW-1:0]                 r_idx;
  logic [CH_NUM-1:0][DW-1:0]     r_shadow;
  logic [CH_NUM-1:0][DW-1:0]     r_ch_data;
  logic [CONVST_W-1:0]           r_convst;
  logic                          r_cs_n, r_rd_n, r_adc_reset, r_ready;
  logic                          r_dv, r_timeout, r_overrun;
  logic                          r_to_flag, r_ov_flag;
  logic                          r_busy_s1, r_busy_s2;
  logic                          w_tick, w_trig, w_busy_fall;

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      logic [31:0] r_auto_cnt;
      // Free-running from the end of RST; wrap-to-zero keeps the period drift-free.
      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                                r_auto_cnt <= '0;
        else if (r_state == S_RST)                   r_auto_cnt <= '0;
        else if (r_auto_cnt == 32'(AUTO_PERIOD - 1)) r_auto_cnt <= '0;
        else                                         r_auto_cnt <= r_auto_cnt + 32'd1;
      end
      assign w_tick = (r_state != S_RST) && (r_auto_cnt == 32'(AUTO_PERIOD - 1));
    end else begin : g_no_auto
      assign w_tick = 1'b0;
    end
  endgenerate

  assign w_trig      = start_i | w_tick;
  assign w_busy_fall = !r_busy_s1 && r_busy_s2;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shadow    <= '0;
      r_ch_data   <= '0;
      r_convst    <= '0;
      r_cs_n      <= 1'b1;
      r_rd_n      <= 1'b1;
      r_adc_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_dv        <= 1'b0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_to_flag   <= 1'b0;
      r_ov_flag   <= 1'b0;
      r_busy_s1   <= 1'b0;
      r_busy_s2   <= 1'b0;
    end else begin
      r_busy_s1   <= busy_i;
      r_busy_s2   <= r_busy_s1;
      // Pin levels and pulses trail the state register by one cycle.
      r_convst    <= {CONVST_W{r_state == S_CONV}};
      r_cs_n      <= !(r_state inside {S_CS, S_RD_LO, S_RD_HI});
      r_rd_n      <= (r_state != S_RD_LO);
      r_adc_reset <= (r_state == S_RST);
      r_ready     <= (r_state == S_IDLE);
      r_dv        <= (r_state == S_DONE);
      r_timeout   <= r_to_flag;
      r_overrun   <= r_ov_flag;
      r_to_flag   <= 1'b0;
      r_ov_flag   <= (r_state != S_IDLE) && w_trig;
      if (r_state == S_DONE) r_ch_data <= r_shadow;
      r_cnt       <= r_cnt + 16'd1;
      case (r_state)
        S_RST: if (r_cnt == 16'(RST_HOLD - 1)) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        S_IDLE: begin
          r_cnt <= '0;
          if (w_trig) r_state <= S_CONV;
        end
        S_CONV: begin
          // Timeout is tested first so it wins over a coincident BUSY fall.
          if (r_cnt == 16'(BUSY_TIMEOUT - 1)) begin
            r_state   <= S_IDLE;
            r_to_flag <= 1'b1;
            r_cnt     <= '0;
          end else if (w_busy_fall) begin
            r_state <= S_CS;
            r_cnt   <= '0;
          end
        end
        S_CS: if (r_cnt == 16'(CS_SETUP - 1)) begin
          r_state <= S_RD_LO;
          r_idx   <= '0;
          r_cnt   <= '0;
        end
        S_RD_LO: if (r_cnt == 16'(RD_LOW - 1)) begin
          r_shadow[r_idx] <= db_i;
          r_state         <= S_RD_HI;
          r_cnt           <= '0;
        end
        S_RD_HI: if (r_cnt == 16'(RD_HIGH - 1)) begin
          r_cnt <= '0;
          if (r_idx == IW'(CH_NUM - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IW'(1);
            r_state <= S_RD_LO;
          end
        end
        S_DONE: begin
          r_state <= S_QUIET;
          r_cnt   <= '0;
        end
        S_QUIET: if (r_cnt == 16'(QUIET - 1)) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
        default: r_state <= S_RST;
      endcase
    end
  end

`ifdef AD76XX_ERR_CNT_EN
  logic [15:0] r_err_cnt;
  logic [16:0] w_err_sum;
  assign w_err_sum = {1'b0, r_err_cnt} + 17'(r_timeout) + 17'(r_overrun);
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i)         r_err_cnt <= '0;
    else if (w_err_sum[16]) r_err_cnt <= 16'hFFFF;
    else                  r_err_cnt <= w_err_sum[15:0];
  end
  assign err_cnt_o = r_err_cnt;
`endif

  assign convst_o     = r_convst;
  assign cs_n_o       = r_cs_n;
  assign rd_n_o       = r_rd_n;
  assign adc_reset_o  = r_adc_reset;
  assign ready_o      = r_ready;
  assign ch_data_o    = r_ch_data;
  assign data_valid_o = r_dv;
  assign timeout_o    = r_timeout;
  assign overrun_o    = r_overrun;

endmodule

// File: tb/tb_ad76xx_par_rd_ctrl.sv
// Bench for ad76xx_par_rd_ctrl: default-parameter DUT plus a self-triggered 4x14-bit DUT, with ADC models.
module tb_ad76xx_par_rd_ctrl;
  localparam int DW = 16, CH = 6, DW2 = 14, CH2 = 4;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic                rst_n = 1'b0, rst2_n = 1'b0, start = 1'b0, start2 = 1'b0;
  logic                busy, busy2;
  logic [DW-1:0]       db = '0;
  logic [DW2-1:0]      db2 = '0;
  logic [2:0]          convst, convst2;
  logic                cs_n, rd_n, adc_rst, ready, dv, to, ov;
  logic                cs_n2, rd_n2, adc_rst2, ready2, dv2, to2, ov2;
  logic [CH*DW-1:0]    ch_data;
  logic [CH2*DW2-1:0]  ch_data2;
`ifdef AD76XX_ERR_CNT_EN
  logic [15:0]         err_cnt, err_cnt2;
`endif

  int checks = 0, failures = 0;
  logic stuck = 1'b0;
  logic [CH*DW-1:0]   exp_q[$];
  logic [CH2*DW2-1:0] exp2_q[$];

  ad76xx_par_rd_ctrl dut (
    .sys_clk_i(sys_clk), .rst_n_i(rst_n), .start_i(start), .busy_i(busy), .db_i(db),
    .convst_o(convst), .cs_n_o(cs_n), .rd_n_o(rd_n), .adc_reset_o(adc_rst), .ready_o(ready),
    .ch_data_o(ch_data), .data_valid_o(dv), .timeout_o(to), .overrun_o(ov)
`ifdef AD76XX_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  ad76xx_par_rd_ctrl #(.CH_NUM(CH2), .DW(DW2), .AUTO_PERIOD(2000)) dut2 (
    .sys_clk_i(sys_clk), .rst_n_i(rst2_n), .start_i(start2), .busy_i(busy2), .db_i(db2),
    .convst_o(convst2), .cs_n_o(cs_n2), .rd_n_o(rd_n2), .adc_reset_o(adc_rst2), .ready_o(ready2),
    .ch_data_o(ch_data2), .data_valid_o(dv2), .timeout_o(to2), .overrun_o(ov2)
`ifdef AD76XX_ERR_CNT_EN
    , .err_cnt_o(err_cnt2)
`endif
  );

  // ADC models: BUSY rises after CONVST, stays high a fixed time, then falls; data changes per RD_N fall.
  int bcnt = 0, bcnt2 = 0, wk = 0, wk2 = 0;
  logic cv_q = 1'b0, cv2_q = 1'b0, rd_q = 1'b1, rd2_q = 1'b1;
  always @(posedge sys_clk) begin
    cv_q  <= convst[0];
    cv2_q <= convst2[0];
    if (convst[0] && !cv_q && !stuck) bcnt <= 102;
    else if (bcnt > 0)               bcnt <= bcnt - 1;
    if (convst2[0] && !cv2_q)        bcnt2 <= 22;
    else if (bcnt2 > 0)              bcnt2 <= bcnt2 - 1;
  end
  assign busy  = (bcnt > 0) && (bcnt <= 100);
  assign busy2 = (bcnt2 > 0) && (bcnt2 <= 20);

  always @(negedge sys_clk) begin
    rd_q  <= rd_n;
    rd2_q <= rd_n2;
    if (cs_n) wk <= 0;
    else if (!rd_n && rd_q) begin db <= 16'(32'h1000 + wk); wk <= wk + 1; end
    if (cs_n2) wk2 <= 0;
    else if (!rd_n2 && rd2_q) begin db2 <= 14'(32'h3FF0 + wk2); wk2 <= wk2 + 1; end
  end

  int dv_cnt = 0, ov_cnt = 0, cv_rise = 0;
  logic cvn_q = 1'b0;
  always @(negedge sys_clk) begin
    cvn_q <= convst[0];
    if (dv) dv_cnt <= dv_cnt + 1;
    if (ov) ov_cnt <= ov_cnt + 1;
    if (convst[0] && !cvn_q) cv_rise <= cv_rise + 1;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic release_and_check_hold(input string name);
    int n;
    rst_n = 1'b1;
    n = 0;
    @(negedge sys_clk);
    while (adc_rst === 1'b1 && n < 100) begin n++; @(negedge sys_clk); end
    checks++;
    if (n !== 16) begin failures++; $display("FAIL %s_hold: adc_reset high %0d cycles, want 16", name, n); end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL %s_ready: ready=%b want 1", name, ready); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({convst, cs_n, rd_n, adc_rst, ready, dv, to, ov} !== 10'b000_1_1_1_0_0_0_0) begin
      failures++;
      $display("FAIL reset_pins: got %b want 0001110000", {convst, cs_n, rd_n, adc_rst, ready, dv, to, ov});
    end
    checks++;
    if (ch_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 0", ch_data); end
    release_and_check_hold("reset");
  endtask

  task automatic push_frame();
    logic [CH*DW-1:0] e;
    for (int k = 0; k < CH; k++) e[k*DW +: DW] = 16'(32'h1000 + k);
    exp_q.push_back(e);
  endtask

  task automatic test_frame();
    int t, fall_t, prev_fall, nlows, bad_w, bad_p, cs_fall, cv_fall, d0, c0;
    logic pcs, pcv, prd, got;
    logic [CH*DW-1:0] e;
    push_frame();
    d0 = dv_cnt; c0 = cv_rise;
    pulse_start();
    t = 0; fall_t = 0; prev_fall = -1; nlows = 0; bad_w = 0; bad_p = 0;
    cs_fall = -1; cv_fall = -2; got = 0;
    pcs = cs_n; pcv = convst[0]; prd = rd_n;
    while (t < 2000 && !got) begin
      @(negedge sys_clk); t++;
      if (!rd_n && prd) begin
        nlows++;
        if (prev_fall >= 0 && t - prev_fall != 12) bad_p++;
        prev_fall = t; fall_t = t;
      end
      if (rd_n && !prd && t - fall_t != 9) bad_w++;
      if (!cs_n && pcs) cs_fall = t;
      if (!convst[0] && pcv) cv_fall = t;
      if (dv) begin
        got = 1;
        checks++;
        if (!(cs_n === 1'b1 && pcs === 1'b0)) begin
          failures++; $display("FAIL frame_cs_rise: cs_n prev=%b now=%b want 0 then 1", pcs, cs_n);
        end
      end
      pcs = cs_n; pcv = convst[0]; prd = rd_n;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL frame_timeout: no data_valid within 2000 cycles"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (ch_data !== e) begin failures++; $display("FAIL frame_data: got %h want %h", ch_data, e); end
    end
    checks++;
    if (nlows !== CH || bad_w !== 0 || bad_p !== 0) begin
      failures++; $display("FAIL frame_rd: lows=%0d bad_width=%0d bad_period=%0d want 6/0/0", nlows, bad_w, bad_p);
    end
    checks++;
    if (cs_fall !== cv_fall) begin
      failures++; $display("FAIL frame_cs_convst: cs_n fell at %0d convst fell at %0d want equal", cs_fall, cv_fall);
    end
    repeat (12) @(negedge sys_clk);
    checks++;
    if (dv_cnt - d0 !== 1 || cv_rise - c0 !== 1) begin
      failures++; $display("FAIL frame_counts: valids=%0d convsts=%0d want 1/1", dv_cnt - d0, cv_rise - c0);
    end
  endtask

  task automatic test_timeout();
    int n, d0;
    logic [CH*DW-1:0] prev;
    stuck = 1'b1;
    prev = ch_data; d0 = dv_cnt;
    pulse_start();
    n = 0;
    while (convst[0] !== 1'b1 && n < 10) begin @(negedge sys_clk); n++; end
    n = 0;
    while (to !== 1'b1 && n < 1000) begin @(negedge sys_clk); n++; end
    checks++;
    if (n !== 400) begin failures++; $display("FAIL timeout_latency: %0d cycles after convst, want 400", n); end
    checks++;
    if (ready !== 1'b1 || convst !== 3'b000) begin
      failures++; $display("FAIL timeout_idle: ready=%b convst=%b want 1/000", ready, convst);
    end
    @(negedge sys_clk);
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL timeout_pulse: timeout_o=%b want 0", to); end
    checks++;
    if (dv_cnt !== d0 || ch_data !== prev) begin
      failures++; $display("FAIL timeout_data: valids=%0d data=%h want 0 new, %h", dv_cnt - d0, ch_data, prev);
    end
    stuck = 1'b0;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_overrun();
    int n, o0, c0;
    logic [CH*DW-1:0] e;
    push_frame();
    o0 = ov_cnt; c0 = cv_rise;
    pulse_start();
    n = 0;
    while (rd_n !== 1'b0 && n < 500) begin @(negedge sys_clk); n++; end
    pulse_start();
    n = 0;
    while (dv !== 1'b1 && n < 500) begin @(negedge sys_clk); n++; end
    checks++;
    if (dv !== 1'b1) begin failures++; $display("FAIL overrun_frame: no data_valid within bound"); end
    else begin
      e = exp_q.pop_front();
      checks++;
      if (ch_data !== e) begin failures++; $display("FAIL overrun_data: got %h want %h", ch_data, e); end
    end
    repeat (20) @(negedge sys_clk);
    checks++;
    if (ov_cnt - o0 !== 1 || cv_rise - c0 !== 1) begin
      failures++; $display("FAIL overrun_counts: overruns=%0d convsts=%0d want 1/1", ov_cnt - o0, cv_rise - c0);
    end
  endtask

  task automatic test_midframe_reset();
    int n, d0;
    pulse_start();
    n = 0;
    while (wk < 3 && n < 500) begin @(negedge sys_clk); n++; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || rd_n !== 1'b1 || convst !== 3'b000 || ch_data !== '0) begin
      failures++; $display("FAIL midreset_pins: cs_n=%b rd_n=%b convst=%b data=%h want 1/1/000/0", cs_n, rd_n, convst, ch_data);
    end
    d0 = dv_cnt;
    repeat (3) @(negedge sys_clk);
    release_and_check_hold("midreset");
    checks++;
    if (dv_cnt !== d0) begin failures++; $display("FAIL midreset_valid: %0d valid pulses want 0", dv_cnt - d0); end
  endtask

  task automatic test_auto();
    int n;
    logic [CH2*DW2-1:0] e, e2;
    for (int k = 0; k < CH2; k++) e[k*DW2 +: DW2] = 14'(32'h3FF0 + k);
    exp2_q.push_back(e);
    n = 0;
    while (dv2 !== 1'b1 && n < 3000) begin @(negedge sys_clk); n++; end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dv2 !== 1'b1) begin failures++; $display("FAIL auto_valid%0d: no data_valid in bound", i); end
      else begin
        e2 = exp2_q.pop_front();
        checks++;
        if (ch_data2 !== e2) begin failures++; $display("FAIL auto_data%0d: got %h want %h", i, ch_data2, e2); end
      end
      if (i == 3) break;
      exp2_q.push_back(e);
      n = 0;
      @(negedge sys_clk); n++;
      while (dv2 !== 1'b1 && n < 2500) begin @(negedge sys_clk); n++; end
      checks++;
      if (n !== 2000) begin failures++; $display("FAIL auto_period%0d: %0d cycles want 2000", i, n); end
    end
  endtask

`ifdef AD76XX_ERR_CNT_EN
  task automatic test_errcnt();
    int n;
    rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    release_and_check_hold("errcnt");
    checks++;
    if (err_cnt !== 16'd0) begin failures++; $display("FAIL errcnt_reset: got %0d want 0", err_cnt); end
    stuck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      if (i < 2) begin repeat (50) @(negedge sys_clk); pulse_start(); end
      n = 0;
      while (to !== 1'b1 && n < 600) begin @(negedge sys_clk); n++; end
      @(negedge sys_clk);
    end
    repeat (3) @(negedge sys_clk);
    checks++;
    if (err_cnt !== 16'd5) begin failures++; $display("FAIL errcnt_count: got %0d want 5", err_cnt); end
    start = 1'b1;
    n = 0;
    while (err_cnt !== 16'hFFFF && n < 70000) begin @(negedge sys_clk); n++; end
    repeat (500) @(negedge sys_clk);
    checks++;
    if (err_cnt !== 16'hFFFF) begin failures++; $display("FAIL errcnt_sat: got %h want ffff", err_cnt); end
    start = 1'b0;
    stuck = 1'b0;
  endtask
`endif

  initial begin
    repeat (2) @(negedge sys_clk);
    rst2_n = 1'b1;
    test_reset();
    test_frame();
    test_timeout();
    test_overrun();
    test_midframe_reset();
    test_auto();
`ifdef AD76XX_ERR_CNT_EN
    test_errcnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
